// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops one word per frame from an upstream FIFO and sends it LSB first.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit before the stop bit.
module fifo_uart_tx #(
   parameter int BIT_DEPTH    = 8,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fifo_empty,
   output logic                 enable_read,
   input  logic [BIT_DEPTH-1:0] value_to_read,
   output logic                 tx,
   output logic                 busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(BIT_DEPTH - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE, FETCH, LOAD, START, DATA, STOP
   } state_t;
`endif

   state_t               state, state_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic [IW-1:0]        idx, idx_n;
   logic [BIT_DEPTH-1:0] shreg, shreg_n;
   logic                 tx_n;
   logic                 bit_end;

   assign bit_end     = (cnt == CNT_LAST);
   assign enable_read = (state == FETCH);
   assign busy        = (state != IDLE);

   // Next-state, counters and the tx value that the next state will present.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      shreg_n = shreg;
      unique case (state)
         IDLE: begin
            if (!fifo_empty) state_n = FETCH;
         end
         FETCH: begin
            state_n = LOAD;
         end
         LOAD: begin
            shreg_n = value_to_read;
            cnt_n   = '0;
            idx_n   = '0;
            state_n = START;
         end
         START: begin
            cnt_n = bit_end ? '0 : cnt + 1'b1;
            if (bit_end) state_n = DATA;
         end
         DATA: begin
            cnt_n = bit_end ? '0 : cnt + 1'b1;
            if (bit_end) begin
               if (idx == IDX_LAST) begin
                  idx_n = '0;
`ifdef UART_TX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end else begin
                  idx_n = idx + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            cnt_n = bit_end ? '0 : cnt + 1'b1;
            if (bit_end) state_n = STOP;
         end
`endif
         STOP: begin
            cnt_n = bit_end ? '0 : cnt + 1'b1;
            if (bit_end) state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      tx_n = 1'b1;
      unique case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shreg_n[idx_n];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_n = ^shreg_n;
`endif
         default: tx_n = 1'b1;
      endcase
   end

   // State, datapath and registered serial output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
         tx    <= 1'b1;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         shreg <= shreg_n;
         tx    <= tx_n;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: random/directed frames checked by a waveform scoreboard.
// FIFO and UART line are modelled as queues and per-cycle expected bit lists.
module tb_fifo_uart_tx;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk;
   logic       rst;
   logic       fifo_empty;
   logic       enable_read;
   logic [7:0] value_to_read;
   logic       tx;
   logic       busy;

   fifo_uart_tx #(
      .BIT_DEPTH(8),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .fifo_empty(fifo_empty),
      .enable_read(enable_read),
      .value_to_read(value_to_read),
      .tx(tx),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   int reads  = 0;
   int exp_reads = 0;

   logic [7:0] fq[$];
   logic [7:0] exp_q[$];

   bit   hold = 1'b0;
   bit   mon_en = 1'b1;
   bit   mon_busy = 1'b0;
   bit   gap_chk = 1'b0;

   task automatic chk(input bit ok, input string name,
                      input int act, input int req);
      total++;
      if (ok) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Upstream FIFO model: word appears after the read strobe, junk otherwise.
   initial begin
      fifo_empty    = 1'b1;
      value_to_read = 8'h00;
   end

   always @(negedge clk) begin
      if (enable_read === 1'b1) begin
         chk(fq.size() != 0, "read_nonempty", fq.size(), 1);
         if (fq.size() != 0) value_to_read = fq.pop_front();
         hold = 1'b1;
         reads++;
      end else if (hold) begin
         hold = 1'b0;
      end else begin
         value_to_read = 8'($urandom);
      end
      fifo_empty = (fq.size() == 0);
   end

   // Line monitor: one expected frame per started frame.
   logic       seq [NB];
   logic       prev_tx = 1'b1;
   logic [7:0] w;
   int         bad;
   int         start_cyc;
   int         last_start = -1;

   initial begin
      forever begin
         @(negedge clk);
         if (!gap_chk) last_start = -1;
         if (mon_en && prev_tx === 1'b1 && tx === 1'b0) begin
            mon_busy  = 1'b1;
            start_cyc = cyc;
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_frame", 1, 0);
               w = 8'h00;
            end else begin
               w = exp_q.pop_front();
            end
            seq[0] = 1'b0;
            for (int i = 0; i < 8; i++) seq[1 + i] = w[i];
`ifdef UART_TX_PARITY_EN
            seq[9] = ^w;
`endif
            seq[NB - 1] = 1'b1;
            bad = 0;
            for (int b = 0; b < NB; b++) begin
               for (int c = 0; c < CPB; c++) begin
                  if (b != 0 || c != 0) @(negedge clk);
                  if (tx !== seq[b] || busy !== 1'b1) bad++;
               end
            end
            chk(bad == 0, $sformatf("frame_%02h", w), bad, 0);
            if (gap_chk && last_start >= 0)
               chk(start_cyc - last_start == NB * CPB + 3, "frame_period",
                   start_cyc - last_start, NB * CPB + 3);
            last_start = gap_chk ? start_cyc : -1;
            @(negedge clk);
            chk(busy === 1'b0 && tx === 1'b1, "idle_after_stop",
                int'(busy), 0);
            mon_busy = 1'b0;
         end
         prev_tx = tx;
      end
   end

   task automatic push(input logic [7:0] v, input bit expect_frame);
      fq.push_back(v);
      if (expect_frame) exp_q.push_back(v);
      exp_reads++;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || fq.size() != 0 || mon_busy ||
              busy !== 1'b0) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk(n < 20000, "drain_timeout", n, 20000);
      repeat (5) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int viol;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk(tx === 1'b1, "reset_tx", int'(tx), 1);
      chk(busy === 1'b0, "reset_busy", int'(busy), 0);
      chk(enable_read === 1'b0, "reset_rd", int'(enable_read), 0);

      viol = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (enable_read !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) viol++;
      end
      chk(viol == 0, "empty_idle", viol, 0);
      chk(reads == 0, "empty_reads", reads, 0);

      push(8'h07, 1'b1);
      drain();
      chk(reads == exp_reads, "single_reads", reads, exp_reads);

      push(8'h0F, 1'b1);
      for (int i = 0; i < 20; i++) begin
         push(8'($urandom), 1'b1);
         repeat ($urandom_range(0, 60)) @(negedge clk);
      end
      drain();
      chk(reads == exp_reads, "random_reads", reads, exp_reads);

      gap_chk = 1'b1;
      for (int i = 8; i <= 17; i++) push(8'(i), 1'b1);
      drain();
      gap_chk = 1'b0;
      chk(reads == exp_reads, "burst_reads", reads, exp_reads);

      mon_en = 1'b0;
      push(8'hA5, 1'b0);
      n = 0;
      while (tx !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(n < 200, "a5_start_timeout", n, 200);
      repeat (4 * CPB + 1) @(negedge clk);
      chk(tx === 1'b0 && busy === 1'b1, "a5_bit3", int'(tx), 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk(tx === 1'b1, "abort_tx", int'(tx), 1);
      chk(busy === 1'b0, "abort_busy", int'(busy), 0);
      chk(enable_read === 1'b0, "abort_rd", int'(enable_read), 0);
      viol = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (enable_read !== 1'b0 || tx !== 1'b1) viol++;
      end
      chk(viol == 0, "abort_quiet", viol, 0);
      chk(reads == exp_reads, "abort_reads", reads, exp_reads);
      mon_en = 1'b1;

      push(8'h3C, 1'b1);
      drain();
      chk(reads == exp_reads, "recover_reads", reads, exp_reads);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter BIT_DEPTH, default 8, meaning data word width in bits, matching the FIFO word width.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-003 Port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port fifo_empty, input, 1, high when the upstream FIFO holds no words.
REQ-006 Port enable_read, output, 1, one-cycle read strobe to the FIFO.
REQ-007 Port value_to_read, input, BIT_DEPTH, FIFO output word; valid on the cycle after enable_read is high.
REQ-008 Port tx, output, 1, UART serial line; idle high.
REQ-009 Port busy, output, 1, high in every state except IDLE.

Function
REQ-010 The FSM SHALL have states IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
REQ-011 IDLE: tx=1; if fifo_empty=0, go to FETCH; otherwise stay in IDLE.
REQ-012 FETCH: enable_read=1 for exactly this one cycle, then go to LOAD unconditionally.
REQ-013 LOAD: capture value_to_read into a BIT_DEPTH shift register, clear the baud counter and bit index, then go to START.
REQ-014 enable_read SHALL be 0 in every state except FETCH; at most one read per frame; no read while fifo_empty=1.
REQ-015 START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-016 DATA: send BIT_DEPTH bits LSB first, each held CLKS_PER_BIT cycles.
REQ-017 The bit index SHALL count 0..BIT_DEPTH-1; after the last bit, go to PARITY if enabled (REQ-025), else to STOP.
REQ-018 STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
REQ-019 Back-to-back frames: the IDLE cycle after STOP SHALL re-sample fifo_empty, giving a 3-cycle gap (IDLE, FETCH, LOAD) with tx=1 between stop bit and next start bit.
REQ-020 The baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, count 0..CLKS_PER_BIT-1, and wrap to 0 at each bit boundary.
REQ-021 tx SHALL be driven from a register and SHALL never glitch.
REQ-022 Changes on fifo_empty or value_to_read outside IDLE or LOAD respectively SHALL not affect the frame in flight.

Reset
REQ-023 On rst=1 at a clk edge, the block SHALL set state=IDLE, tx=1, enable_read=0, busy=0, and clear the counters and the shift register.
REQ-024 Reset mid-frame SHALL abort the frame immediately; the word is lost and no extra FIFO read occurs.

Configuration
REQ-025 Macro UART_TX_PARITY_EN: when defined, the PARITY state sends the even-parity bit (XOR of the data bits) for CLKS_PER_BIT cycles between DATA and STOP.
REQ-026 When UART_TX_PARITY_EN is undefined, the PARITY state and its logic SHALL be absent, and DATA goes directly to STOP.

Verification
REQ-027 Reset: rst high 2 cycles -> tx=1, busy=0, enable_read=0 on the cycle after release.
REQ-028 Single word: CLKS_PER_BIT=4, fifo_empty=0 then 1 after one read, value 8'h07 -> exactly one enable_read pulse; tx=0 for 4 clks, then 1,1,1,0,0,0,0,0 (4 clks each), then stop=1; busy falls after 40 clks of frame.
REQ-029 Empty FIFO: fifo_empty=1 for 100 cycles -> enable_read never asserts; tx=1; busy=0.
REQ-030 Burst: words 8..17 (10 words) available -> 10 reads, 10 frames, 3-cycle idle gap between stop and next start, order preserved.
REQ-031 Mid-frame reset: rst during DATA bit 3 of 8'hA5 -> tx=1 next cycle, state IDLE, no enable_read before fifo_empty is resampled.
REQ-032 Parity build with UART_TX_PARITY_EN: 8'h07 -> parity bit 1; 8'h0F -> parity bit 0; frame length 11 bit times.
